if_id_stage: RTL and testbench

//  Parametrised IF->ID pipeline stage register with valid/ready handshake, flush and stall accounting.

---
 rtl/if_id_pkg.sv | 15 +
 rtl/if_id_stage_pipe_slot.sv | 34 +++
 rtl/if_id_stage.sv | 103 ++++++++++
 tb/tb_if_id_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
// Shared constants and payload type for the IF->ID stage register.
package if_id_pkg;

  localparam int PC_W_DFLT    = 64;
  localparam int INSTR_W_DFLT = 32;

  // Architectural NOP shown to decode whenever the stage holds a bubble.
  localparam logic [INSTR_W_DFLT-1:0] NOP_INSTR_DFLT = 32'hD503201F;

  typedef struct packed {
    logic [PC_W_DFLT-1:0]    pc;
    logic [INSTR_W_DFLT-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/if_id_stage_pipe_slot.sv
// One pipeline slot: a valid bit plus a payload register.
// Load has priority over clear, so a slot can be refilled in the same cycle it drains.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/if_id_stage.sv
// IF->ID stage register with valid/ready handshake, flush, NOP on bubble and saturating stall counter.
// Define IF_ID_SKID_EN to add a 1-entry skid slot that registers in_ready.
module if_id_stage
  import if_id_pkg::*;
#(
  parameter int                  PC_W      = 64,
  parameter int                  INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = NOP_INSTR_DFLT,
  parameter int                  CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int               PKT_W   = PC_W + INSTR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             accept;
  logic             release_s;
  logic             main_valid;
  logic             main_load;
  logic             main_clear;
  logic [PKT_W-1:0] main_d;
  logic [PKT_W-1:0] main_q;
  logic [CNT_W-1:0] stall_d;
  logic [CNT_W-1:0] stall_q;

  assign accept    = in_valid && in_ready;
  assign release_s = main_valid && out_ready;

`ifdef IF_ID_SKID_EN
  logic             skid_valid;
  logic             skid_load;
  logic             skid_clear;
  logic [PKT_W-1:0] skid_q;

  assign in_ready = !skid_valid;

  // A waiting skid entry always refills main before any new fetch, preserving order.
  assign main_load  = !flush && (skid_valid ? release_s : (accept && (!main_valid || release_s)));
  assign main_d     = skid_valid ? skid_q : {pc_in, instr_in};
  assign skid_load  = !flush && accept && main_valid && !release_s;
  assign skid_clear = flush || (skid_valid && release_s);

  pipe_slot #(.W(PKT_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  ({pc_in, instr_in}),
    .valid_o (skid_valid),
    .data_o  (skid_q)
  );
`else
  assign in_ready  = out_ready || !main_valid;
  assign main_load = !flush && accept;
  assign main_d    = {pc_in, instr_in};
`endif

  assign main_clear = flush || (release_s && !main_load);

  pipe_slot #(.W(PKT_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load_i  (main_load),
    .clear_i (main_clear),
    .data_i  (main_d),
    .valid_o (main_valid),
    .data_o  (main_q)
  );

  // NOTE: stall_d gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    stall_d = stall_q;
    if (flush) begin
      stall_d = '0;
    end else if (main_valid && !out_ready && (stall_q != CNT_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign out_valid = main_valid;
  // pc_out keeps the last loaded PC through bubbles; only the instruction is replaced.
  assign pc_out    = main_q[PKT_W-1:INSTR_W];
  assign instr_out = main_valid ? main_q[INSTR_W-1:0] : NOP_INSTR;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: queue-based model compared every cycle plus directed literal checks.
module tb_if_id_stage;
  import if_id_pkg::*;

  localparam int          PC_W    = 64;
  localparam int          INSTR_W = 32;
  localparam int          CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP     = 32'hD503201F;
`ifdef IF_ID_SKID_EN
  localparam int          DEPTH   = 2;
`else
  localparam int          DEPTH   = 1;
`endif

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [PC_W-1:0]    pc_in = '0;
  logic [INSTR_W-1:0] instr_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instr_out;
  logic [CNT_W-1:0]   stall_cnt;

  if_id_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pc_in     (pc_in),
    .instr_in  (instr_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pc_out    (pc_out),
    .instr_out (instr_out),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return 32'hA500_0000 ^ pc[31:0];
  endfunction

  // Model: the stage is a FIFO of capacity DEPTH; outputs follow its head.
  fetch_pkt_t   q[$];
  int           m_cnt;
  logic [63:0]  m_last_pc;
  logic         m_acc;
  fetch_pkt_t   pkt;

  function automatic logic model_ready();
    if (DEPTH == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_cnt     = 0;
      m_last_pc = '0;
      m_acc     = 1'b0;
    end else begin
      m_acc = in_valid && model_ready();
      if (flush) begin
        q.delete();
        m_cnt = 0;
      end else begin
        if (q.size() > 0 && !out_ready && m_cnt < CNT_MAX) m_cnt++;
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (m_acc) begin
          pkt.pc    = pc_in;
          pkt.instr = instr_in;
          q.push_back(pkt);
        end
      end
      if (q.size() > 0) m_last_pc = q[0].pc;
    end
  end

  logic        sb_en = 1'b0;
  logic [63:0] exp_del;

  always @(negedge clk) begin
    if (!reset) begin
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("pc_out", pc_out, m_last_pc);
      check("instr_out", 64'(instr_out), 64'((q.size() > 0) ? q[0].instr : NOP));
      check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
      check("in_ready", 64'(in_ready), 64'(model_ready()));
      if (sb_en && out_valid && out_ready) begin
        check("delivery_order", pc_out, exp_del);
        exp_del += 64'd4;
      end
    end
  end

  task automatic cyc(input logic v, input logic [63:0] pc, input logic rdy, input logic fl);
    in_valid  = v;
    pc_in     = pc;
    instr_in  = instr_of(pc);
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] src_pc;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Stream: three back-to-back items emerge one cycle later with no gaps.
    cyc(1, 64'h0, 1, 0);
    check("stream0_valid", 64'(out_valid), 64'd1);
    check("stream0_pc", pc_out, 64'h0);
    cyc(1, 64'h4, 1, 0);
    check("stream1_pc", pc_out, 64'h4);
    cyc(1, 64'h8, 1, 0);
    check("stream2_pc", pc_out, 64'h8);
    check("stream2_instr", 64'(instr_out), 64'(32'hA500_0008));
    cyc(0, 64'h0, 1, 0);
    check("stream_empty_valid", 64'(out_valid), 64'd0);
    check("stream_empty_instr", 64'(instr_out), 64'(NOP));
    check("stream_empty_pc_held", pc_out, 64'h8);

    // Asynchronous reset in the middle of a stalled transfer.
    cyc(1, 64'h50, 0, 0);
    cyc(0, 64'h0, 0, 0);
    cyc(0, 64'h0, 0, 0);
    check("pre_reset_cnt", 64'(stall_cnt), 64'd2);
    #2 reset = 1'b1;
    #1;
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_instr", 64'(instr_out), 64'(32'hD503201F));
    check("reset_pc", pc_out, 64'h0);
    check("reset_cnt", 64'(stall_cnt), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Stall for five cycles with a second item waiting, then release in order.
    cyc(1, 64'h10, 0, 0);
    repeat (5) cyc(1, 64'h14, 0, 0);
    check("stall_pc", pc_out, 64'h10);
    check("stall_cnt5", 64'(stall_cnt), 64'd5);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    cyc(1, 64'h14, 1, 0);
    check("stall_next_pc", pc_out, 64'h14);
    cyc(0, 64'h0, 1, 0);
    check("stall_drained", 64'(out_valid), 64'd0);
    check("stall_cnt_kept", 64'(stall_cnt), 64'd5);

    // Flush with occupied stage and an offered item; then flush of an empty stage.
    cyc(1, 64'h20, 0, 0);
    cyc(1, 64'h24, 0, 0);
    cyc(1, 64'h28, 0, 1);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_instr", 64'(instr_out), 64'(NOP));
    check("flush_cnt", 64'(stall_cnt), 64'd0);
    check("flush_pc_held", pc_out, 64'h20);
    cyc(1, 64'h2C, 1, 1);
    check("flush_drop_accept", 64'(out_valid), 64'd0);
    cyc(1, 64'h30, 1, 0);
    check("post_flush_pc", pc_out, 64'h30);
    cyc(0, 64'h0, 1, 0);

    // Saturation: twenty stalled cycles on a 4-bit counter.
    cyc(1, 64'h40, 0, 0);
    repeat (20) cyc(0, 64'h0, 0, 0);
    check("sat_cnt", 64'(stall_cnt), 64'd15);
    cyc(0, 64'h0, 1, 0);
    check("sat_release", 64'(out_valid), 64'd0);
    check("sat_cnt_kept", 64'(stall_cnt), 64'd15);

    // Random valid/ready traffic; delivered PCs must be strictly consecutive.
    src_pc  = 64'h1000;
    exp_del = 64'h1000;
    sb_en   = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      cyc(($urandom_range(0, 3) != 0), src_pc, ($urandom_range(0, 2) != 0), 0);
      if (m_acc) src_pc += 64'd4;
    end
    repeat (4) cyc(0, 64'h0, 1, 0);
    check("random_no_loss", exp_del, src_pc);
    sb_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
